// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - N-way set-associative instruction cache with subblock valids and ranged clear
// Tag/data RAMs are read synchronously from iaddr; LOOKUP compares all ways and a miss refills one subblock.
module icache_assoc #(
   parameter int WAYS = 2,
   parameter int SETW = 6,
   parameter int SBW  = 1,
   parameter int WPS  = 2
) (
   input  logic            CLK,
   input  logic            RES,
   input  logic            CE,
   input  logic            ice,
   input  logic            ireq,
   input  logic [29:0]     iaddr,
   output logic            iack,
   output logic [31:0]     idata,
   output logic            mreq,
   output logic [29:0]     maddr,
   input  logic            mack,
   input  logic [31:0]     mdata,
   input  logic            clr_start,
   input  logic [SETW-1:0] clr_base,
   input  logic [SETW:0]   clr_count,
   output logic            clr_busy
);
   localparam int WB    = $clog2(WPS);
   localparam int WBW   = (WB > 0) ? WB : 1;
   localparam int NSB   = 1 << SBW;
   localparam int NSETS = 1 << SETW;
   localparam int TAGW  = 30 - WB - SBW - SETW;
   localparam int TEW   = NSB + TAGW;
   localparam int DIW   = WB + SBW + SETW;
   localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP, BYPASS, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [29:0]       addr_q, addr_d;
   logic [29:0]       maddr_q, maddr_d;
   logic              mreq_q, mreq_d;
   logic [31:0]       idata_q, idata_d;
   logic              clr_busy_q, clr_busy_d;
   logic [SETW-1:0]   clr_ptr_q, clr_ptr_d;
   logic [SETW:0]     clr_cnt_q, clr_cnt_d;
   logic [WW-1:0]     vict_q, vict_d;
   logic [NSB-1:0]    keep_q, keep_d;
   logic [WW-1:0]     rr_q [NSETS];
   logic              rr_adv, tag_we, data_we, clr_we;

   logic [TEW-1:0]    tag_ram  [WAYS][NSETS];
   logic [31:0]       data_ram [WAYS][NSETS*NSB*WPS];
   logic [TEW-1:0]    tag_rd   [WAYS];
   logic [31:0]       data_rd  [WAYS];

   logic [SETW-1:0]   a_set, r_set;
   logic [TAGW-1:0]   a_tag;
   logic [NSB-1:0]    sb_oh;
   logic [WBW-1:0]    a_word, beat;

   logic              hit, tm_found, em_found;
   logic [31:0]       hit_word;
   logic [WW-1:0]     tm_way, em_way;
   logic [NSB-1:0]    tm_valid;

   assign a_set  = addr_q[WB+SBW +: SETW];
   assign a_tag  = addr_q[29 -: TAGW];
   assign r_set  = iaddr[WB+SBW +: SETW];
   assign sb_oh  = NSB'(1) << ((addr_q >> WB) & 30'(NSB-1));
   assign a_word = WBW'(addr_q & 30'(WPS-1));
   assign beat   = WBW'(maddr_q & 30'(WPS-1));

   assign mreq     = mreq_q;
   assign maddr    = maddr_q;
   assign clr_busy = clr_busy_q;

   // A subblock-invalid tag match wins over an empty way so the line's other subblocks survive.
   always_comb begin
      hit      = 1'b0;
      hit_word = '0;
      tm_found = 1'b0;
      tm_way   = '0;
      tm_valid = '0;
      em_found = 1'b0;
      em_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (tag_rd[w][TAGW-1:0] == a_tag) begin
            if ((tag_rd[w][TEW-1 -: NSB] & sb_oh) != '0) begin
               hit      = 1'b1;
               hit_word = data_rd[w];
            end else if (!tm_found) begin
               tm_found = 1'b1;
               tm_way   = WW'(w);
               tm_valid = tag_rd[w][TEW-1 -: NSB];
            end
         end
         if (tag_rd[w][TEW-1 -: NSB] == '0 && !em_found) begin
            em_found = 1'b1;
            em_way   = WW'(w);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      maddr_d    = maddr_q;
      mreq_d     = mreq_q;
      idata_d    = idata_q;
      clr_busy_d = clr_busy_q;
      clr_ptr_d  = clr_ptr_q;
      clr_cnt_d  = clr_cnt_q;
      vict_d     = vict_q;
      keep_d     = keep_q;
      rr_adv     = 1'b0;
      tag_we     = 1'b0;
      data_we    = 1'b0;
      clr_we     = 1'b0;
      iack       = 1'b0;
      idata      = idata_q;

      if (clr_start && !clr_busy_q) begin
         clr_busy_d = 1'b1;
         clr_ptr_d  = clr_base;
         clr_cnt_d  = clr_count;
      end

      case (state_q)
         IDLE: begin
            if (clr_start || clr_busy_q) begin
               state_d = CLEAR;
            end else if (ireq) begin
               addr_d = iaddr;
               if (ice) begin
                  state_d = LOOKUP;
               end else begin
                  state_d = BYPASS;
                  mreq_d  = 1'b1;
                  maddr_d = iaddr;
               end
            end
         end
         LOOKUP: begin
            if (hit) begin
               iack    = 1'b1;
               idata   = hit_word;
               state_d = IDLE;
            end else begin
               if (tm_found) begin
                  vict_d = tm_way;
                  keep_d = tm_valid;
               end else if (em_found) begin
                  vict_d = em_way;
                  keep_d = '0;
               end else begin
                  vict_d = rr_q[a_set];
                  keep_d = '0;
                  rr_adv = 1'b1;
               end
               mreq_d  = 1'b1;
               maddr_d = addr_q & ~30'(WPS-1);
               state_d = FILL;
            end
         end
         FILL: begin
            if (mack) begin
               data_we = 1'b1;
               if (beat == a_word) idata_d = mdata;
               if (beat == WBW'(WPS-1)) begin
                  tag_we  = 1'b1;
                  mreq_d  = 1'b0;
                  state_d = RESP;
               end else begin
                  maddr_d = maddr_q + 30'd1;
               end
            end
         end
         BYPASS: begin
            if (mack) begin
               idata_d = mdata;
               mreq_d  = 1'b0;
               state_d = RESP;
            end
         end
         RESP: begin
            iack    = 1'b1;
            state_d = IDLE;
         end
         CLEAR: begin
            if (clr_cnt_q == '0) begin
               clr_busy_d = 1'b0;
               state_d    = IDLE;
            end else begin
               clr_we    = 1'b1;
               clr_ptr_d = clr_ptr_q + SETW'(1);
               clr_cnt_d = clr_cnt_q - (SETW+1)'(1);
               if (clr_cnt_q == (SETW+1)'(1)) begin
                  clr_busy_d = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         maddr_q    <= '0;
         mreq_q     <= 1'b0;
         idata_q    <= '0;
         clr_busy_q <= 1'b0;
         clr_ptr_q  <= '0;
         clr_cnt_q  <= '0;
         vict_q     <= '0;
         keep_q     <= '0;
         for (int s = 0; s < NSETS; s++) rr_q[s] <= '0;
      end else if (CE) begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         maddr_q    <= maddr_d;
         mreq_q     <= mreq_d;
         idata_q    <= idata_d;
         clr_busy_q <= clr_busy_d;
         clr_ptr_q  <= clr_ptr_d;
         clr_cnt_q  <= clr_cnt_d;
         vict_q     <= vict_d;
         keep_q     <= keep_d;
         if (rr_adv)
            rr_q[a_set] <= (rr_q[a_set] == WW'(WAYS-1)) ? '0 : rr_q[a_set] + WW'(1);
      end
   end

   // RAMs carry no reset; only the clear engine invalidates lines.
   always_ff @(posedge CLK) begin
      if (CE) begin
         for (int w = 0; w < WAYS; w++) begin
            tag_rd[w]  <= tag_ram[w][r_set];
            data_rd[w] <= data_ram[w][iaddr[DIW-1:0]];
         end
         if (data_we) data_ram[vict_q][maddr_q[DIW-1:0]] <= mdata;
         if (tag_we) tag_ram[vict_q][a_set] <= {keep_q | sb_oh, a_tag};
         if (clr_we) begin
            for (int w = 0; w < WAYS; w++) tag_ram[w][clr_ptr_q] <= '0;
         end
      end
   end
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed table-driven bench for icache_assoc
// A bus model returns address-derived words with a selectable salt so cached and bypassed data differ.
module tb_icache_assoc;
   logic        CLK, RES, CE, ice, ireq, iack, mreq, mack, clr_start, clr_busy;
   logic [29:0] iaddr, maddr;
   logic [31:0] idata, mdata, salt;
   logic [5:0]  clr_base;
   logic [6:0]  clr_count;

   int checks = 0;
   int errors = 0;
   logic [29:0] beats[$];

   localparam logic [31:0] S1 = 32'h1111_0000;

   typedef struct {
      logic [31:0] ba;
      logic        ice_v;
      logic [31:0] s;
      int          nb;
      int          lat;
      logic [31:0] fb;
      logic [31:0] d;
      bit          ct;
      int          tw;
      logic [23:0] tv;
      bit          cr;
      int          rrv;
   } vec_t;
   vec_t vt[$];

   icache_assoc dut (
      .CLK(CLK), .RES(RES), .CE(CE), .ice(ice), .ireq(ireq), .iaddr(iaddr),
      .iack(iack), .idata(idata), .mreq(mreq), .maddr(maddr), .mack(mack),
      .mdata(mdata), .clr_start(clr_start), .clr_base(clr_base),
      .clr_count(clr_count), .clr_busy(clr_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mw(input logic [31:0] ba, input logic [31:0] s);
      return ba ^ 32'h5A5A_0F0F ^ s;
   endfunction

   always @(negedge CLK) begin
      mack  = mreq;
      mdata = mw({maddr, 2'b00}, salt);
   end

   always @(posedge CLK) begin
      if (!RES && CE && mreq && mack) beats.push_back(maddr);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] ba, input logic ice_v,
                        output logic [31:0] d, output int lat, output bit ok);
      @(negedge CLK);
      beats.delete();
      iaddr = ba[31:2];
      ice   = ice_v;
      ireq  = 1'b1;
      lat   = 0;
      ok    = 1'b0;
      d     = '0;
      while (!ok && lat < 200) begin
         @(negedge CLK);
         lat++;
         if (iack) begin
            ok = 1'b1;
            d  = idata;
         end
      end
      ireq = 1'b0;
   endtask

   task automatic do_clear(input logic [5:0] base, input logic [6:0] cnt, output int cyc);
      @(negedge CLK);
      clr_base  = base;
      clr_count = cnt;
      clr_start = 1'b1;
      @(negedge CLK);
      clr_start = 1'b0;
      cyc = 0;
      while (clr_busy && cyc < 500) begin
         cyc++;
         @(negedge CLK);
      end
   endtask

   task automatic add(input logic [31:0] ba, input logic ice_v, input logic [31:0] s,
                      input int nb, input int lat, input logic [31:0] fb, input logic [31:0] d,
                      input bit ct, input int tw, input logic [23:0] tv, input bit cr, input int rrv);
      vec_t v;
      v.ba = ba; v.ice_v = ice_v; v.s = s; v.nb = nb; v.lat = lat; v.fb = fb; v.d = d;
      v.ct = ct; v.tw = tw; v.tv = tv; v.cr = cr; v.rrv = rrv;
      vt.push_back(v);
   endtask

   task automatic expect_fetch(input string name, input logic [31:0] ba, input int nb, input logic [31:0] exp_d);
      logic [31:0] d;
      int          lat;
      bit          ok;
      fetch(ba, 1'b1, d, lat, ok);
      chk({name, "_ack"}, ok, 1);
      chk({name, "_data"}, d, exp_d);
      chk({name, "_beats"}, beats.size(), nb);
   endtask

   initial begin
      logic [31:0] d;
      int          lat, cyc, busy_cyc, n;
      bit          ok, early, got;
      logic [23:0] vacc;

      RES = 1'b1; CE = 1'b1; ice = 1'b0; ireq = 1'b0; iaddr = '0;
      clr_start = 1'b0; clr_base = '0; clr_count = '0; salt = '0;
      mack = 1'b0; mdata = '0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_iack", iack, 0);
      chk("rst_idata", idata, 0);
      chk("rst_mreq", mreq, 0);
      chk("rst_maddr", maddr, 0);
      chk("rst_clr_busy", clr_busy, 0);
      RES = 1'b0;

      // full clear with a fetch raised while the engine is busy
      @(negedge CLK);
      clr_base = 6'd0; clr_count = 7'd64; clr_start = 1'b1;
      @(negedge CLK);
      clr_start = 1'b0;
      busy_cyc = 0; early = 1'b0; got = 1'b0; d = '0;
      beats.delete();
      for (int c = 0; c < 400; c++) begin
         if (clr_busy) busy_cyc++;
         if (iack) begin
            if (clr_busy) early = 1'b1;
            got  = 1'b1;
            d    = idata;
            ireq = 1'b0;
            break;
         end
         if (c == 5) begin
            iaddr = 30'h2000_0006;
            ice   = 1'b1;
            ireq  = 1'b1;
         end
         @(negedge CLK);
      end
      chk("clr64_busy_cycles", busy_cyc, 64);
      chk("clr64_no_early_iack", early, 0);
      chk("miss0_ack", got, 1);
      chk("miss0_data", d, mw(32'h8000_0018, 0));
      chk("miss0_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         chk("miss0_beat0", beats[0], 30'h2000_0006);
         chk("miss0_beat1", beats[1], 30'h2000_0007);
      end
      vacc = '0;
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 64; s++)
            if (s != 1) vacc = vacc | dut.tag_ram[w][s];
      chk("clr64_valid_zero", vacc[23:22], 0);
      chk("miss0_tag", dut.tag_ram[0][1], {2'b10, 22'h200000});

      add(32'h8000_001C, 1, 0,  0, 1, 0,            mw(32'h8000_001C, 0),  0, 0, 0,                   0, 0);
      add(32'h8000_0010, 1, 0,  2, 4, 32'h8000_0010, mw(32'h8000_0010, 0), 1, 0, {2'b11, 22'h200000}, 0, 0);
      add(32'h8000_0014, 1, 0,  0, 1, 0,            mw(32'h8000_0014, 0),  0, 0, 0,                   0, 0);
      add(32'h8000_0018, 1, 0,  0, 1, 0,            mw(32'h8000_0018, 0),  0, 0, 0,                   0, 0);
      add(32'h8000_0418, 1, 0,  2, 4, 32'h8000_0418, mw(32'h8000_0418, 0), 1, 1, {2'b10, 22'h200001}, 0, 0);
      add(32'h8000_0818, 1, 0,  2, 4, 32'h8000_0818, mw(32'h8000_0818, 0), 1, 0, {2'b10, 22'h200002}, 1, 1);
      add(32'h8000_041C, 1, 0,  0, 1, 0,            mw(32'h8000_041C, 0),  0, 0, 0,                   0, 0);
      add(32'h8000_0010, 1, 0,  2, 4, 32'h8000_0010, mw(32'h8000_0010, 0), 1, 1, {2'b01, 22'h200000}, 1, 0);
      add(32'h8000_081C, 1, 0,  0, 1, 0,            mw(32'h8000_081C, 0),  0, 0, 0,                   0, 0);
      add(32'h8000_0418, 1, 0,  2, 4, 32'h8000_0418, mw(32'h8000_0418, 0), 1, 0, {2'b10, 22'h200001}, 1, 1);
      add(32'h8000_0014, 0, S1, 1, 2, 32'h8000_0014, mw(32'h8000_0014, S1), 1, 1, {2'b01, 22'h200000}, 0, 0);
      add(32'h8000_0014, 1, S1, 0, 1, 0,            mw(32'h8000_0014, 0),  0, 0, 0,                   0, 0);
      add(32'h8000_0020, 0, S1, 1, 2, 32'h8000_0020, mw(32'h8000_0020, S1), 0, 0, 0,                  0, 0);
      add(32'h8000_0020, 1, S1, 2, 4, 32'h8000_0020, mw(32'h8000_0020, S1), 0, 0, 0,                  0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         salt = vt[i].s;
         if (i == 13) chk("byp_set2_untouched", dut.tag_ram[0][2][23:22] | dut.tag_ram[1][2][23:22], 0);
         fetch(vt[i].ba, vt[i].ice_v, d, lat, ok);
         chk($sformatf("v%0d_ack", i), ok, 1);
         chk($sformatf("v%0d_data", i), d, vt[i].d);
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_beats", i), beats.size(), vt[i].nb);
         if (vt[i].nb > 0 && beats.size() > 0) chk($sformatf("v%0d_beat0", i), beats[0], vt[i].fb[31:2]);
         if (vt[i].ct) chk($sformatf("v%0d_tag", i), dut.tag_ram[vt[i].tw][1], vt[i].tv);
         if (vt[i].cr) chk($sformatf("v%0d_rr", i), dut.rr_q[1], vt[i].rrv);
      end

      // reset in the middle of a fill
      @(negedge CLK);
      beats.delete();
      iaddr = 30'h2000_000C; ice = 1'b1; ireq = 1'b1;
      n = 0;
      while (!mreq && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("rstfill_mreq_seen", mreq, 1);
      @(posedge CLK);
      #2 RES = 1'b1;
      #1;
      chk("rstfill_beat0_taken", beats.size(), 1);
      chk("rstfill_mreq", mreq, 0);
      chk("rstfill_iack", iack, 0);
      chk("rstfill_maddr", maddr, 0);
      ireq = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RES = 1'b0;
      expect_fetch("rstfill_refetch", 32'h8000_0030, 2, mw(32'h8000_0030, S1));

      // wrap-around clear of sets 62, 63, 0, 1
      expect_fetch("fill_s61", 32'h8000_03D0, 2, mw(32'h8000_03D0, S1));
      expect_fetch("fill_s62", 32'h8000_03E0, 2, mw(32'h8000_03E0, S1));
      expect_fetch("fill_s63", 32'h8000_03F0, 2, mw(32'h8000_03F0, S1));
      expect_fetch("fill_s0",  32'h8000_0000, 2, mw(32'h8000_0000, S1));
      chk("wrap_pre_s62_valid", dut.tag_ram[0][62][23:22], 2'b01);
      do_clear(6'd62, 7'd4, cyc);
      chk("wrap_busy_cycles", cyc, 4);
      vacc = '0;
      for (int w = 0; w < 2; w++) begin
         vacc = vacc | dut.tag_ram[w][62] | dut.tag_ram[w][63] | dut.tag_ram[w][0] | dut.tag_ram[w][1];
      end
      chk("wrap_cleared_valid", vacc[23:22], 0);
      expect_fetch("wrap_s61_hit", 32'h8000_03D0, 0, mw(32'h8000_03D0, S1));
      expect_fetch("wrap_s2_hit",  32'h8000_0020, 0, mw(32'h8000_0020, S1));
      expect_fetch("wrap_s3_hit",  32'h8000_0030, 0, mw(32'h8000_0030, S1));
      expect_fetch("wrap_s62_miss", 32'h8000_03E0, 2, mw(32'h8000_03E0, S1));

      do_clear(6'd10, 7'd0, cyc);
      chk("clr0_busy_cycles", cyc, 1);
      expect_fetch("clr0_s62_hit", 32'h8000_03E0, 0, mw(32'h8000_03E0, S1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
